// File: rtl/pbit_bank.sv
// pbit_bank: bank of probabilistic bits with per-channel LFSR, saturating beta-scaled activation and parallel or round-robin update
// CLK, RST: rising-edge clock, asynchronous active-low reset
// en: advance enable; mode: 0 parallel, 1 round-robin; beta: extra activation shift
// z: packed signed biases, channel i at [i*BIAS_W +: BIAS_W]
// pbit_val: registered states; update_idx: channel sampled this cycle; sweep_done: sweep-commit pulse
module pbit_bank #(
  parameter int NUM_PBITS = 4,
  parameter int BIAS_W = 8,
  parameter int ACT_SHIFT = 24,
  parameter logic [31:0] SEED = 32'd1,
  localparam int IW = NUM_PBITS > 1 ? $clog2(NUM_PBITS) : 1
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic                          en,
  input  logic                          mode,
  input  logic [3:0]                    beta,
  input  logic [NUM_PBITS*BIAS_W-1:0]   z,
  output logic [NUM_PBITS-1:0]          pbit_val,
  output logic [IW-1:0]                 update_idx,
  output logic                          sweep_done
);
  // wide enough to hold the bias shifted by ACT_SHIFT+15 without loss
  localparam int AW0 = BIAS_W + ACT_SHIFT + 16;
  localparam int AW = AW0 > 34 ? AW0 : 34;
  localparam logic signed [AW-1:0] HI = {{(AW-32){1'b0}}, 32'h8000_0000};
  localparam logic signed [AW-1:0] LO = -HI;
  logic [NUM_PBITS-1:0] hit;
  logic [NUM_PBITS-1:0] mask_q;
  logic last_q;
  logic v_q;
  logic last_idx;
  for (genvar i = 0; i < NUM_PBITS; i++) begin : g_ch
    localparam logic [31:0] S0 = SEED ^ (32'(i) * 32'h9E37_79B9);
    localparam logic [31:0] S = S0 == 32'd0 ? 32'd1 : S0;
    logic [31:0] lfsr;
    logic [31:0] r_q;
    logic [32:0] a;
    logic [32:0] a_q;
    logic signed [AW-1:0] wide;
    logic [33:0] sum;
    assign wide = $signed({{(AW-BIAS_W){z[i*BIAS_W+BIAS_W-1]}}, z[i*BIAS_W +: BIAS_W]}) <<< (ACT_SHIFT + int'(beta));
    // clamp to the 33-bit range [-2^31, +2^31] so the extremes dominate any LFSR value
    assign a = wide > HI ? 33'h0_8000_0000 : wide < LO ? 33'h1_8000_0000 : wide[32:0];
    // 34-bit sum of sign-extended operands cannot overflow; its msb is the sign
    assign sum = {a_q[32], a_q} + {{2{r_q[31]}}, r_q};
    assign hit[i] = ~sum[33];
    always_ff @(posedge CLK or negedge RST)
      if (!RST) begin
        lfsr <= S;
        a_q <= '0;
        r_q <= '0;
      end else if (en) begin
        lfsr <= lfsr[0] ? (lfsr >> 1) ^ 32'h8020_0003 : lfsr >> 1;
        a_q <= a;
        r_q <= lfsr;
      end
  end
  assign last_idx = update_idx == IW'(NUM_PBITS - 1);
  always_ff @(posedge CLK or negedge RST)
    if (!RST) begin
      mask_q <= '0;
      last_q <= 1'b0;
      v_q <= 1'b0;
      update_idx <= '0;
      pbit_val <= '0;
      sweep_done <= 1'b0;
    end else begin
      sweep_done <= en & v_q & last_q;
      if (en) begin
        pbit_val <= v_q ? (pbit_val & ~mask_q) | (hit & mask_q) : pbit_val;
        mask_q <= mode ? NUM_PBITS'(1) << update_idx : '1;
        last_q <= ~mode | last_idx;
        v_q <= 1'b1;
        // parallel mode and any switch into it park the index at 0
        update_idx <= mode & ~last_idx ? update_idx + 1'b1 : '0;
      end
    end
endmodule

// File: tb/tb_pbit_bank.sv
// tb_pbit_bank: table vectors, corner sequences, statistics and random stimulus against a transaction-level model
module tb_pbit_bank;
  localparam int N = 4;
  localparam int BW = 8;
  localparam logic [31:0] ZP = 32'h807F_807F;
  localparam logic [31:0] ZNEG = 32'h8080_8080;
  localparam logic [31:0] ZPOS = 32'h7F7F_7F7F;
  logic CLK = 1'b0;
  logic RST = 1'b0;
  logic en = 1'b0;
  logic mode = 1'b0;
  logic [3:0] beta = '0;
  logic [N*BW-1:0] z = '0;
  logic [N-1:0] pbit_val;
  logic [1:0] update_idx;
  logic sweep_done;
  pbit_bank #(.NUM_PBITS(N)) dut (
    .CLK(CLK), .RST(RST), .en(en), .mode(mode), .beta(beta), .z(z),
    .pbit_val(pbit_val), .update_idx(update_idx), .sweep_done(sweep_done)
  );
  always #5 CLK = ~CLK;
  int n_cmp = 0;
  int n_bad = 0;
  // reference model: LFSR states, one pending sample, committed outputs
  logic [31:0] lf [N];
  bit pv;
  longint pa [N];
  longint pr [N];
  logic [N-1:0] pm;
  bit pl;
  logic [N-1:0] m_pbit;
  bit m_done;
  int m_idx;
  typedef struct {
    bit e;
    bit m;
    logic [3:0] b;
    logic [N*BW-1:0] zz;
    logic [N-1:0] pb;
    bit d;
    int ix;
  } vec_t;
  vec_t tv [14];
  logic [N-1:0] rec [20];
  int ones [N];
  int both [N][N];
  real px, py, pxy, c;
  logic [N-1:0] hold_pb;
  logic [N*BW-1:0] rz;
  bit rm;
  function automatic logic [31:0] lfsr_next(logic [31:0] x);
    return x[0] ? (x >> 1) ^ 32'h8020_0003 : x >> 1;
  endfunction
  function automatic longint act(logic signed [7:0] zi, int b);
    longint v;
    v = longint'(zi) * (longint'(1) << (24 + b));
    if (v > 64'sd2147483648) v = 64'sd2147483648;
    if (v < -64'sd2147483648) v = -64'sd2147483648;
    return v;
  endfunction
  task automatic model_reset();
    logic [31:0] s;
    for (int i = 0; i < N; i++) begin
      s = 32'd1 ^ (32'(i) * 32'h9E37_79B9);
      lf[i] = (s == 0) ? 32'd1 : s;
    end
    pv = 0;
    pm = '0;
    pl = 0;
    m_pbit = '0;
    m_done = 0;
    m_idx = 0;
  endtask
  task automatic chk(string nm, logic [63:0] got, logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d at %0t", nm, got, want, $time);
    end
  endtask
  task automatic chk_rng(string nm, real v, real lo, real hi);
    n_cmp++;
    if (!(v >= lo && v <= hi)) begin
      n_bad++;
      $display("FAIL %s: got %f want [%f,%f]", nm, v, lo, hi);
    end
  endtask
  task automatic do_reset();
    @(negedge CLK);
    RST = 1'b0;
    en = 1'b0;
    #1;
    chk("reset_pbit", pbit_val, 0);
    chk("reset_done", sweep_done, 0);
    chk("reset_idx", update_idx, 0);
    model_reset();
    @(negedge CLK);
    RST = 1'b1;
  endtask
  task automatic step(bit e, bit m, logic [3:0] b, logic [N*BW-1:0] zz);
    en = e;
    mode = m;
    beta = b;
    z = zz;
    @(posedge CLK);
    if (e) begin
      if (pv)
        for (int i = 0; i < N; i++)
          if (pm[i]) m_pbit[i] = (pr[i] + pa[i] >= 0);
      m_done = pv && pl;
      for (int i = 0; i < N; i++) begin
        pa[i] = act(zz[i*BW +: BW], int'(b));
        pr[i] = longint'($signed(lf[i]));
        lf[i] = lfsr_next(lf[i]);
      end
      pm = '0;
      if (m) pm[m_idx] = 1'b1;
      else pm = '1;
      pl = !m || m_idx == N - 1;
      pv = 1;
      m_idx = m ? (m_idx + 1) % N : 0;
    end else m_done = 0;
    #1;
    chk("model_pbit", pbit_val, m_pbit);
    chk("model_done", sweep_done, m_done);
    chk("model_idx", update_idx, m_idx);
  endtask
  initial begin
    tv[0]  = '{1'b1, 1'b0, 4'd1, ZP,   4'b0000, 1'b0, 0};
    tv[1]  = '{1'b1, 1'b0, 4'd1, ZP,   4'b0101, 1'b1, 0};
    tv[2]  = '{1'b1, 1'b0, 4'd1, ZP,   4'b0101, 1'b1, 0};
    tv[3]  = '{1'b0, 1'b0, 4'd1, ZP,   4'b0101, 1'b0, 0};
    tv[4]  = '{1'b1, 1'b0, 4'd2, ZNEG, 4'b0101, 1'b1, 0};
    tv[5]  = '{1'b1, 1'b1, 4'd2, ZPOS, 4'b0000, 1'b1, 1};
    tv[6]  = '{1'b1, 1'b1, 4'd2, ZPOS, 4'b0001, 1'b0, 2};
    tv[7]  = '{1'b1, 1'b1, 4'd2, ZPOS, 4'b0011, 1'b0, 3};
    tv[8]  = '{1'b0, 1'b1, 4'd2, ZPOS, 4'b0011, 1'b0, 3};
    tv[9]  = '{1'b1, 1'b1, 4'd2, ZPOS, 4'b0111, 1'b0, 0};
    tv[10] = '{1'b1, 1'b1, 4'd2, ZPOS, 4'b1111, 1'b1, 1};
    tv[11] = '{1'b1, 1'b1, 4'd2, ZNEG, 4'b1111, 1'b0, 2};
    tv[12] = '{1'b1, 1'b0, 4'd2, ZPOS, 4'b1101, 1'b0, 0};
    tv[13] = '{1'b1, 1'b0, 4'd2, ZPOS, 4'b1111, 1'b1, 0};
    do_reset();
    for (int k = 0; k < 14; k++) begin
      step(tv[k].e, tv[k].m, tv[k].b, tv[k].zz);
      chk("tab_pbit", pbit_val, tv[k].pb);
      chk("tab_done", sweep_done, tv[k].d);
      chk("tab_idx", update_idx, tv[k].ix);
    end
    // parallel saturation holds for 1000 cycles
    for (int k = 0; k < 1000; k++) begin
      step(1'b1, 1'b0, 4'd1, ZP);
      if (k >= 1) begin
        chk("sat_pbit", pbit_val, 4'b0101);
        chk("sat_done", sweep_done, 1);
      end
    end
    // en gating in sequential mode at index 2
    for (int k = 0; k < 8 && update_idx != 2; k++) step(1'b1, 1'b1, 4'd0, 32'h0);
    chk("reach_idx2", update_idx, 2);
    hold_pb = pbit_val;
    for (int k = 0; k < 50; k++) begin
      step(1'b0, 1'b1, 4'($urandom_range(0, 15)), 32'($urandom));
      chk("gate_pbit", pbit_val, hold_pb);
      chk("gate_idx", update_idx, 2);
      chk("gate_done", sweep_done, 0);
    end
    step(1'b1, 1'b1, 4'd0, 32'h0);
    chk("gate_resume_idx", update_idx, 3);
    // asynchronous reset mid-run replays the LFSR streams
    do_reset();
    for (int k = 0; k < 20; k++) begin
      step(1'b1, 1'b0, 4'd0, 32'h0);
      rec[k] = pbit_val;
    end
    #2;
    RST = 1'b0;
    #1;
    chk("async_pbit", pbit_val, 0);
    chk("async_done", sweep_done, 0);
    chk("async_idx", update_idx, 0);
    model_reset();
    RST = 1'b1;
    for (int k = 0; k < 20; k++) begin
      step(1'b1, 1'b0, 4'd0, 32'h0);
      chk("replay_pbit", pbit_val, rec[k]);
    end
    // statistics at z=0: balance and pairwise decorrelation
    for (int i = 0; i < N; i++) begin
      ones[i] = 0;
      for (int j = 0; j < N; j++) both[i][j] = 0;
    end
    for (int k = 0; k < 10000; k++) begin
      step(1'b1, 1'b0, 4'd0, 32'h0);
      for (int i = 0; i < N; i++) begin
        ones[i] += int'(pbit_val[i]);
        for (int j = i + 1; j < N; j++) both[i][j] += int'(pbit_val[i] & pbit_val[j]);
      end
    end
    for (int i = 0; i < N; i++) chk_rng("stat_half", real'(ones[i]) / 10000.0, 0.48, 0.52);
    for (int i = 0; i < N; i++)
      for (int j = i + 1; j < N; j++) begin
        px = real'(ones[i]) / 10000.0;
        py = real'(ones[j]) / 10000.0;
        pxy = real'(both[i][j]) / 10000.0;
        c = (pxy - px * py) / $sqrt(px * (1.0 - px) * py * (1.0 - py));
        chk_rng("stat_corr", c, -0.05, 0.05);
      end
    // z=32: a=2^29 gives P(1)=0.625
    for (int i = 0; i < N; i++) ones[i] = 0;
    for (int k = 0; k < 10000; k++) begin
      step(1'b1, 1'b0, 4'd0, 32'h2020_2020);
      for (int i = 0; i < N; i++) ones[i] += int'(pbit_val[i]);
    end
    for (int i = 0; i < N; i++) chk_rng("stat_625", real'(ones[i]) / 10000.0, 0.605, 0.645);
    // random stimulus against the model
    rm = 1'b0;
    for (int k = 0; k < 2000; k++) begin
      rz = 32'($urandom);
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 3) == 0) rz[i*BW +: BW] = $urandom_range(0, 1) ? 8'h7F : 8'h80;
      step($urandom_range(0, 3) != 0, rm, 4'($urandom_range(0, 15)), rz);
      if ($urandom_range(0, 19) == 0) rm = ~rm;
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
